core_cycle_sequencer: RTL and testbench

Sequences one destructive-readout core memory cycle (read, sense strobe, rewrite) from the active-low one-hot X/Y select lines produced by the address register X/Y decode stage. Sits directly downstream of that decoder: it validates and encodes the AX ones/eights and AY selects, drives half-select read and write currents, captures sense-amplifier data, and rewrites either the restored word or new write data via inhibit drivers. Also checks odd parity per syllable on read data.

---
 rtl/core_cycle_pkg.sv | 22 ++
 rtl/onehot_n_encode.sv | 19 +
 rtl/core_cycle_sequencer.sv | 147 ++++++++++++++
 tb/tb_core_cycle_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/core_cycle_pkg.sv
// Shared types, default timing and the syllable parity helper for the core memory cycle sequencer.
package core_cycle_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_WRITE,
        S_RECOVER
    } state_t;

    localparam int W_DEF     = 28;
    localparam int T_RD_DEF  = 3;
    localparam int T_WR_DEF  = 3;
    localparam int T_REC_DEF = 2;

    // A syllable is good when it carries an odd number of ones; zero-extension does not change that.
    function automatic logic syl_odd(input logic [63:0] syl);
        return ^syl;
    endfunction

endpackage

// File: rtl/onehot_n_encode.sv
// Active-low one-hot select group to binary index, with a flag that exactly one line is low.
module onehot_n_encode (
    input  logic [7:0] sel_n,
    output logic [2:0] idx,
    output logic       valid
);

    logic [7:0] act;

    always_comb begin
        act = ~sel_n;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (act[i]) idx = 3'(i);
        end
        valid = (act != '0) && ((act & (act - 8'd1)) == '0);
    end

endmodule

// File: rtl/core_cycle_sequencer.sv
// Sequences one destructive-readout core cycle: address check, read + strobe, rewrite, recovery.
module core_cycle_sequencer
    import core_cycle_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int T_RD  = T_RD_DEF,
    parameter int T_WR  = T_WR_DEF,
    parameter int T_REC = T_REC_DEF
) (
    input  logic         CLK,
    input  logic         RESETN,
    input  logic         START,
    input  logic         WRMODE,
    input  logic [W-1:0] WDATA,
    input  logic [7:0]   AXN,
    input  logic [7:0]   AX0N,
    input  logic [7:0]   AYN,
    input  logic [W-1:0] SENSE,
    output logic [5:0]   XSEL,
    output logic [2:0]   YSEL,
    output logic         XRD,
    output logic         YRD,
    output logic         XWR,
    output logic         YWR,
    output logic         STROBE,
    output logic [W-1:0] INHN,
    output logic [W-1:0] RDATA,
    output logic         BUSY,
    output logic         DONE,
    output logic         ADDRERR,
    output logic         PARERR
);

    state_t       state, state_nx;
    logic [7:0]   cnt, cnt_nx;
    logic [5:0]   xsel_nx;
    logic [2:0]   ysel_nx;
    logic [W-1:0] rdata_nx, wdata_l, wdata_nx;
    logic         wrmode_l, wrmode_nx, parerr_nx, done_nx, addrerr_nx;

    logic [2:0] ones_idx, eights_idx, y_idx;
    logic       ones_ok, eights_ok, y_ok;

    onehot_n_encode u_ones   (.sel_n(AXN),  .idx(ones_idx),   .valid(ones_ok));
    onehot_n_encode u_eights (.sel_n(AX0N), .idx(eights_idx), .valid(eights_ok));
    onehot_n_encode u_y      (.sel_n(AYN),  .idx(y_idx),      .valid(y_ok));

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state    <= S_IDLE;
            cnt      <= '0;
            XSEL     <= '0;
            YSEL     <= '0;
            RDATA    <= '0;
            PARERR   <= 1'b0;
            DONE     <= 1'b0;
            ADDRERR  <= 1'b0;
            wdata_l  <= '0;
            wrmode_l <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            XSEL     <= xsel_nx;
            YSEL     <= ysel_nx;
            RDATA    <= rdata_nx;
            PARERR   <= parerr_nx;
            DONE     <= done_nx;
            ADDRERR  <= addrerr_nx;
            wdata_l  <= wdata_nx;
            wrmode_l <= wrmode_nx;
        end
    end

    // One down-counter serves READ, WRITE and RECOVER; it is reloaded on every state entry.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        xsel_nx    = XSEL;
        ysel_nx    = YSEL;
        rdata_nx   = RDATA;
        parerr_nx  = PARERR;
        wdata_nx   = wdata_l;
        wrmode_nx  = wrmode_l;
        done_nx    = 1'b0;
        addrerr_nx = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nx  = S_ADDR;
                    wdata_nx  = WDATA;
                    wrmode_nx = WRMODE;
                    parerr_nx = 1'b0;
                end
            end
            S_ADDR: begin
                if (ones_ok && eights_ok && y_ok) begin
                    xsel_nx  = {eights_idx, ones_idx};
                    ysel_nx  = y_idx;
                    cnt_nx   = 8'(T_RD - 1);
                    state_nx = S_READ;
                end else begin
                    done_nx    = 1'b1;
                    addrerr_nx = 1'b1;
                    state_nx   = S_IDLE;
                end
            end
            S_READ: begin
                if (cnt == '0) begin
                    rdata_nx = SENSE;
                    if (!wrmode_l && !(syl_odd(64'(SENSE[W/2-1:0])) && syl_odd(64'(SENSE[W-1:W/2]))))
                        parerr_nx = 1'b1;
                    cnt_nx   = 8'(T_WR - 1);
                    state_nx = S_WRITE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_WRITE: begin
                if (cnt == '0) begin
                    cnt_nx   = 8'(T_REC - 1);
                    state_nx = S_RECOVER;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_RECOVER: begin
                if (cnt == '0) begin
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Drives decode straight from state, so read and write enables can never overlap.
    assign XRD    = (state == S_READ);
    assign YRD    = (state == S_READ);
    assign XWR    = (state == S_WRITE);
    assign YWR    = (state == S_WRITE);
    assign STROBE = (state == S_READ) && (cnt == '0);
    assign INHN   = (state == S_WRITE) ? (wrmode_l ? wdata_l : RDATA) : '1;
    assign BUSY   = (state != S_IDLE);

endmodule

// File: tb/tb_core_cycle_sequencer.sv
// Directed and randomized cycles checked against a cycle-indexed reference model of the sequencer.
module tb_core_cycle_sequencer;

    localparam int W        = 28;
    localparam int T_RD     = 3;
    localparam int T_WR     = 3;
    localparam int T_REC    = 2;
    localparam int BUSY_LEN = 1 + T_RD + T_WR + T_REC;

    logic         CLK = 1'b0;
    logic         RESETN = 1'b0;
    logic         START = 1'b0;
    logic         WRMODE = 1'b0;
    logic [W-1:0] WDATA = '0;
    logic [7:0]   AXN = 8'hFF;
    logic [7:0]   AX0N = 8'hFF;
    logic [7:0]   AYN = 8'hFF;
    logic [W-1:0] SENSE = '0;
    logic [5:0]   XSEL;
    logic [2:0]   YSEL;
    logic         XRD, YRD, XWR, YWR, STROBE, BUSY, DONE, ADDRERR, PARERR;
    logic [W-1:0] INHN, RDATA;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] model_rdata = '0;
    bit           model_perr = 1'b0;

    always #5 CLK = ~CLK;

    core_cycle_sequencer #(.W(W), .T_RD(T_RD), .T_WR(T_WR), .T_REC(T_REC)) dut (
        .CLK(CLK), .RESETN(RESETN), .START(START), .WRMODE(WRMODE), .WDATA(WDATA),
        .AXN(AXN), .AX0N(AX0N), .AYN(AYN), .SENSE(SENSE),
        .XSEL(XSEL), .YSEL(YSEL), .XRD(XRD), .YRD(YRD), .XWR(XWR), .YWR(YWR),
        .STROBE(STROBE), .INHN(INHN), .RDATA(RDATA), .BUSY(BUSY), .DONE(DONE),
        .ADDRERR(ADDRERR), .PARERR(PARERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Index of the single low line; returns whether exactly one line is low.
    function automatic bit sel_decode(input logic [7:0] v, output int idx);
        int lows = 0;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i] == 1'b0) begin
                lows++;
                idx = i;
            end
        end
        return lows == 1;
    endfunction

    function automatic bit par_bad(input logic [W-1:0] w);
        return ($countones(w[W/2-1:0]) % 2 == 0) || ($countones(w[W-1:W/2]) % 2 == 0);
    endfunction

    function automatic logic [7:0] rnd_sel();
        logic [7:0] t;
        if ($urandom_range(0, 5) == 0) return 8'($urandom);
        t = 8'h01 << $urandom_range(0, 7);
        return ~t;
    endfunction

    task automatic check_reset();
        chk("rst_xsel", 32'(XSEL), 32'(0));
        chk("rst_ysel", 32'(YSEL), 32'(0));
        chk("rst_drv", 32'({XRD, YRD, XWR, YWR, STROBE}), 32'(0));
        chk("rst_inhn", 32'(INHN), 32'({W{1'b1}}));
        chk("rst_rdata", 32'(RDATA), 32'(0));
        chk("rst_flags", 32'({BUSY, DONE, ADDRERR, PARERR}), 32'(0));
        model_rdata = '0;
        model_perr  = 1'b0;
    endtask

    task automatic idle(input int n);
        START = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            chk("idle_busy_done", 32'({BUSY, DONE, ADDRERR}), 32'(0));
            chk("idle_parerr", 32'(PARERR), 32'(model_perr));
            chk("idle_inhn", 32'(INHN), 32'({W{1'b1}}));
            chk("idle_drv", 32'({XRD, YRD, XWR, YWR, STROBE}), 32'(0));
        end
    endtask

    // Starts from an idle or DONE cycle; returns while sampling the DONE cycle (or abort cycle).
    task automatic run_cycle(input bit wm, input logic [W-1:0] wd, input logic [7:0] ax,
                             input logic [7:0] ax0, input logic [7:0] ay, input logic [W-1:0] sn,
                             input bit hold, input int abort_at);
        int o, e, y;
        bit ok, pbad, in_rd, in_wr, cap;
        WRMODE = wm; WDATA = wd; AXN = ax; AX0N = ax0; AYN = ay; SENSE = sn; START = 1'b1;
        ok   = sel_decode(ax, o) & sel_decode(ax0, e) & sel_decode(ay, y);
        pbad = !wm && par_bad(sn);
        tick();
        if (!hold) START = 1'b0;
        model_perr = 1'b0;
        chk("addr_busy", 32'(BUSY), 32'(1));
        chk("addr_parerr_clr", 32'(PARERR), 32'(0));
        chk("addr_drv", 32'({XRD, YRD, XWR, YWR, STROBE}), 32'(0));
        chk("addr_inhn", 32'(INHN), 32'({W{1'b1}}));
        WDATA  = W'($urandom);
        WRMODE = ~wm;
        tick();
        AXN = 8'($urandom); AX0N = 8'($urandom); AYN = 8'($urandom);
        if (!ok) begin
            chk("err_pulse", 32'({ADDRERR, DONE, BUSY}), 32'(3'b110));
            chk("err_drv", 32'({XRD, YRD, XWR, YWR, STROBE}), 32'(0));
            chk("err_rdata", 32'(RDATA), 32'(model_rdata));
            return;
        end
        for (int i = 2; i <= BUSY_LEN + 1; i++) begin
            if (i == abort_at) return;
            in_rd = (i <= 1 + T_RD);
            in_wr = (i > 1 + T_RD) && (i <= 1 + T_RD + T_WR);
            cap   = (i > 1 + T_RD);
            chk("busy", 32'(BUSY), 32'(i <= BUSY_LEN));
            chk("done", 32'(DONE), 32'(i == BUSY_LEN + 1));
            chk("addrerr_low", 32'(ADDRERR), 32'(0));
            chk("rd_en", 32'({XRD, YRD}), in_rd ? 32'(3) : 32'(0));
            chk("wr_en", 32'({XWR, YWR}), in_wr ? 32'(3) : 32'(0));
            chk("strobe", 32'(STROBE), 32'(i == 1 + T_RD));
            chk("xsel", 32'(XSEL), 32'(e * 8 + o));
            chk("ysel", 32'(YSEL), 32'(y));
            chk("inhn", 32'(INHN), in_wr ? 32'(wm ? wd : sn) : 32'({W{1'b1}}));
            chk("rdata", 32'(RDATA), cap ? 32'(sn) : 32'(model_rdata));
            chk("parerr", 32'(PARERR), cap ? 32'(pbad) : 32'(0));
            if (cap) begin
                model_rdata = sn;
                model_perr  = pbad;
            end
            if (i <= BUSY_LEN) begin
                tick();
                if (i == 1 + T_RD) SENSE = W'($urandom);
            end
        end
    endtask

    initial begin
        tick();
        tick();
        check_reset();
        RESETN = 1'b1;
        idle(1);

        // read-restore, odd parity in both syllables
        run_cycle(1'b0, W'($urandom), 8'hF7, 8'hDF, 8'hBF, 28'h0004001, 1'b0, 0);
        idle(2);
        // clear-write
        run_cycle(1'b1, 28'hABCDEF1, 8'hFE, 8'h7F, 8'hFE, 28'h1234567, 1'b0, 0);
        idle(1);
        // two lows on Y
        run_cycle(1'b0, W'($urandom), 8'hF7, 8'hDF, 8'hFC, W'($urandom), 1'b0, 0);
        idle(1);
        // no low on X ones
        run_cycle(1'b1, W'($urandom), 8'hFF, 8'hDF, 8'hBF, W'($urandom), 1'b0, 0);
        idle(1);
        // even parity: sticky past DONE, cleared by next accept
        run_cycle(1'b0, W'($urandom), 8'hF7, 8'hDF, 8'hBF, 28'h0000003, 1'b0, 0);
        idle(3);
        run_cycle(1'b0, W'($urandom), 8'hBF, 8'hFB, 8'h7F, 28'h0004001, 1'b0, 0);
        idle(1);
        // START held high: back-to-back acceptance in the DONE cycle, mid-cycle START ignored
        run_cycle(1'b0, W'($urandom), 8'hEF, 8'hEF, 8'hEF, 28'h0000003, 1'b1, 0);
        run_cycle(1'b1, W'($urandom), 8'hFD, 8'hF7, 8'hFB, W'($urandom), 1'b1, 0);
        run_cycle(1'b0, W'($urandom), 8'h00, 8'hF7, 8'hFB, W'($urandom), 1'b1, 0);
        run_cycle(1'b0, W'($urandom), 8'h7F, 8'h7F, 8'h7F, 28'h0004001, 1'b0, 0);
        idle(1);
        // reset in the middle of WRITE after a bad-parity capture
        run_cycle(1'b0, W'($urandom), 8'hF7, 8'hDF, 8'hBF, 28'h0000003, 1'b0, 2 + T_RD + 1);
        RESETN = 1'b0;
        tick();
        check_reset();
        RESETN = 1'b1;
        idle(2);
        run_cycle(1'b0, W'($urandom), 8'hF7, 8'hDF, 8'hBF, 28'h0004001, 1'b0, 0);
        idle(1);

        for (int n = 0; n < 30; n++) begin
            run_cycle(1'($urandom), W'($urandom), rnd_sel(), rnd_sel(), rnd_sel(), W'($urandom),
                      1'($urandom_range(0, 3) == 0), 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
